atm_counter_arbiter: RTL and testbench

//  Shares one 64-bit event counter among NREQ bus requesters over a 32-bit read path.
//  - On grant, snapshots the full 64-bit count_i in one cycle.
//  - Returns the snapshot in two acked beats: low word, then high word. The two words
//    are never torn.
//  - Sits between the counter datapath and the microcontroller bus masters.
//  - Round-robin fairness across requesters.

---
 rtl/atm_counter_arbiter.sv | 149 ++++++++++++++
 tb/tb_atm_counter_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_counter_arbiter.sv
// Round-robin arbiter sharing one 64-bit event counter over a 32-bit, two-beat read path.
// Optional macro CLEAR_ON_READ_EN: pulse cnt_clr_o on every snapshot so reads return deltas.
module atm_counter_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic [63:0]     count_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o,
  output logic            ack_o,
  output logic [31:0]     data_o,
  output logic            last_o,
  output logic            busy_o,
  output logic            cnt_clr_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_e;

`ifdef CLEAR_ON_READ_EN
  localparam logic CLR_EN = 1'b1;
`else
  localparam logic CLR_EN = 1'b0;
`endif

  state_e          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  rr_ptr_d;
  logic [63:0]     snap_q;
  logic [NREQ-1:0] gnt_q;
  logic [IDW-1:0]  gnt_id_q;
  logic            ack_q;
  logic [31:0]     data_q;
  logic            last_q;
  logic            busy_q;
  logic            cnt_clr_q;

  logic [NREQ-1:0] elig_mask;
  logic [IDW-1:0]  win_idx;
  logic [IDW-1:0]  scan_idx;
  logic            win_vld;

  function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] v);
    if (v == IDW'(NREQ - 1)) begin
      return {IDW{1'b0}};
    end else begin
      return v + IDW'(1);
    end
  endfunction

  // Rotating-priority search; in HI the pointer is already advanced past the grantee
  // and the grantee itself is masked so it cannot be regranted back to back.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    elig_mask = req_i;
    if (state_q == HI) begin
      rr_ptr_d  = inc_wrap(gnt_id_q);
      elig_mask = req_i & ~gnt_q;
    end else begin
      rr_ptr_d  = rr_ptr_q;
      elig_mask = req_i;
    end
    win_vld  = 1'b0;
    win_idx  = rr_ptr_d;
    scan_idx = rr_ptr_d;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_vld && elig_mask[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end else begin
        win_vld = win_vld;
      end
      scan_idx = inc_wrap(scan_idx);
    end
  end

  // Transfer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= {IDW{1'b0}};
      snap_q    <= 64'd0;
      gnt_q     <= {NREQ{1'b0}};
      gnt_id_q  <= {IDW{1'b0}};
      ack_q     <= 1'b0;
      data_q    <= 32'd0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      cnt_clr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HI: begin
          rr_ptr_q <= rr_ptr_d;
          if (win_vld) begin
            state_q   <= LO;
            snap_q    <= count_i;
            gnt_q     <= NREQ'(1) << win_idx;
            gnt_id_q  <= win_idx;
            ack_q     <= 1'b1;
            data_q    <= count_i[31:0];
            last_q    <= 1'b0;
            busy_q    <= 1'b1;
            cnt_clr_q <= CLR_EN;
          end else begin
            state_q   <= IDLE;
            gnt_q     <= {NREQ{1'b0}};
            gnt_id_q  <= {IDW{1'b0}};
            ack_q     <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            cnt_clr_q <= 1'b0;
          end
        end
        LO: begin
          state_q   <= HI;
          ack_q     <= 1'b1;
          data_q    <= snap_q[63:32];
          last_q    <= 1'b1;
          busy_q    <= 1'b1;
          cnt_clr_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          gnt_q     <= {NREQ{1'b0}};
          gnt_id_q  <= {IDW{1'b0}};
          ack_q     <= 1'b0;
          last_q    <= 1'b0;
          busy_q    <= 1'b0;
          cnt_clr_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_id_o  = gnt_id_q;
  assign ack_o     = ack_q;
  assign data_o    = data_q;
  assign last_o    = last_q;
  assign busy_o    = busy_q;
  assign cnt_clr_o = cnt_clr_q;

endmodule

// File: tb/tb_atm_counter_arbiter.sv
// Self-checking bench for atm_counter_arbiter: directed scenarios plus random traffic
// against a transfer-level reference model (rotating scan, pending high-word beat).
module tb_atm_counter_arbiter;
  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [63:0]  cnt = 64'd0;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_id;
  logic         ack;
  logic [31:0]  data;
  logic         last;
  logic         busy;
  logic         clr;

  atm_counter_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rst(rst), .req_i(req), .count_i(cnt),
    .gnt_o(gnt), .gnt_id_o(gnt_id), .ack_o(ack), .data_o(data),
    .last_o(last), .busy_o(busy), .cnt_clr_o(clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int           m_ptr = 0;
  int           m_gid = 0;
  bit           m_hi = 1'b0;
  bit           m_pend = 1'b0;
  logic [31:0]  m_hiword = 32'd0;
  logic         e_ack = 1'b0, e_last = 1'b0, e_busy = 1'b0, e_clr = 1'b0;
  logic [N-1:0] e_gnt = '0;
  logic [W-1:0] e_id = '0;
  logic [31:0]  e_data = 32'd0;

  task automatic model_edge();
    logic [N-1:0] elig;
    int w;
    if (!rst) begin
      m_ptr = 0; m_hi = 1'b0; m_pend = 1'b0;
      e_ack = 1'b0; e_last = 1'b0; e_busy = 1'b0; e_clr = 1'b0;
      e_gnt = '0; e_id = '0; e_data = 32'd0;
    end else if (m_pend) begin
      m_pend = 1'b0; m_hi = 1'b1;
      e_ack = 1'b1; e_last = 1'b1; e_data = m_hiword; e_clr = 1'b0;
    end else begin
      elig = req;
      if (m_hi) begin
        m_ptr = (m_gid + 1) % N;
        elig[m_gid] = 1'b0;
      end
      m_hi = 1'b0; e_clr = 1'b0; w = -1;
      for (int i = 0; i < N; i++)
        if (w < 0 && elig[(m_ptr + i) % N]) w = (m_ptr + i) % N;
      if (w >= 0) begin
        m_gid = w; e_gnt = N'(1) << w; e_id = W'(w);
        m_hiword = cnt[63:32]; e_data = cnt[31:0]; m_pend = 1'b1;
        e_ack = 1'b1; e_last = 1'b0; e_busy = 1'b1;
`ifdef CLEAR_ON_READ_EN
        e_clr = 1'b1;
`endif
      end else begin
        e_ack = 1'b0; e_last = 1'b0; e_busy = 1'b0; e_gnt = '0; e_id = '0;
      end
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq, input logic [63:0] c);
    rst = r; req = rq; cnt = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1111, 64'd0);
      n_tests++;
      if ({gnt, gnt_id, ack, data, last, busy, clr} !== '0) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got gnt=%b id=%0d ack=%b data=%h last=%b busy=%b clr=%b, want all 0",
                 i, gnt, gnt_id, ack, data, last, busy, clr);
      end
    end
    step(1'b1, 4'b1111, 64'd7);
    n_tests++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || ack !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: got gnt=%b id=%0d ack=%b, want 0001/0/1", gnt, gnt_id, ack);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0000, 64'd7);
      n_tests++;
      if ({ack, last, busy, gnt, gnt_id, clr} !== {e_ack, e_last, e_busy, e_gnt, e_id, e_clr} ||
          (e_ack && data !== e_data)) begin
        n_fail++;
        $display("FAIL reset_drain cyc%0d: got ack=%b last=%b gnt=%b data=%h, want %b %b %b %h",
                 i, ack, last, gnt, data, e_ack, e_last, e_gnt, e_data);
      end
    end
  endtask

  task automatic test_single_read();
    logic [63:0] c;
    c = 64'h0123_4567_89AB_CDEF;
    step(1'b1, 4'b0100, c);
    n_tests++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2 || ack !== 1'b1 || last !== 1'b0 || data !== 32'h89AB_CDEF) begin
      n_fail++;
      $display("FAIL single_lo: got gnt=%b id=%0d ack=%b last=%b data=%h, want 0100/2/1/0/89abcdef",
               gnt, gnt_id, ack, last, data);
    end
    step(1'b1, 4'b0000, c);
    n_tests++;
    if (gnt !== 4'b0100 || ack !== 1'b1 || last !== 1'b1 || data !== 32'h0123_4567) begin
      n_fail++;
      $display("FAIL single_hi: got gnt=%b ack=%b last=%b data=%h, want 0100/1/1/01234567", gnt, ack, last, data);
    end
    step(1'b1, 4'b0000, c);
    n_tests++;
    if (ack !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000 || last !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got ack=%b busy=%b gnt=%b last=%b, want 0/0/0000/0", ack, busy, gnt, last);
    end
  endtask

  task automatic test_no_tear();
    step(1'b1, 4'b0001, 64'h0000_0000_FFFF_FFFF);
    n_tests++;
    if (data !== 32'hFFFF_FFFF || ack !== 1'b1) begin
      n_fail++;
      $display("FAIL tear_lo: got ack=%b data=%h, want 1/ffffffff", ack, data);
    end
    step(1'b1, 4'b0000, 64'h0000_0001_0000_0000);
    n_tests++;
    if (data !== 32'h0000_0000 || last !== 1'b1) begin
      n_fail++;
      $display("FAIL tear_hi: got last=%b data=%h, want 1/00000000", last, data);
    end
    step(1'b1, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b1, 4'b0000, 64'd0);
    n_tests++;
    if (data !== 32'hFFFF_FFFF || last !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_hi: got last=%b data=%h, want 1/ffffffff", last, data);
    end
    step(1'b1, 4'b0000, 64'd0);
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_id;
    step(1'b0, 4'b0000, 64'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'b1111, {32'(i), 32'(i + 100)});
      exp_id = W'(i / 2);
      n_tests++;
      if (gnt_id !== exp_id || ack !== 1'b1 || last !== 1'(i % 2) ||
          gnt !== e_gnt || data !== e_data) begin
        n_fail++;
        $display("FAIL rr cyc%0d: got id=%0d ack=%b last=%b data=%h, want id=%0d ack=1 last=%0d data=%h",
                 i, gnt_id, ack, last, data, exp_id, i % 2, e_data);
      end
    end
    step(1'b1, 4'b0000, 64'd0);
    step(1'b1, 4'b0000, 64'd0);
  endtask

  task automatic test_drop_and_reset();
    step(1'b1, 4'b0010, 64'h5555_0000_AAAA_1111);
    step(1'b1, 4'b0000, 64'd0);
    n_tests++;
    if (ack !== 1'b1 || last !== 1'b1 || gnt !== 4'b0010 || data !== 32'h5555_0000) begin
      n_fail++;
      $display("FAIL drop_hi: got ack=%b last=%b gnt=%b data=%h, want 1/1/0010/55550000", ack, last, gnt, data);
    end
    step(1'b1, 4'b0001, 64'd9);
    step(1'b0, 4'b0001, 64'd9);
    n_tests++;
    if (ack !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset: got ack=%b gnt=%b busy=%b, want 0/0000/0", ack, gnt, busy);
    end
    step(1'b1, 4'b1111, 64'd3);
    n_tests++;
    if (gnt_id !== 2'd0 || gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset_ptr: got id=%0d gnt=%b, want 0/0001", gnt_id, gnt);
    end
    step(1'b1, 4'b0000, 64'd0);
    step(1'b1, 4'b0000, 64'd0);
  endtask

  task automatic test_clear();
    logic exp_clr;
`ifdef CLEAR_ON_READ_EN
    exp_clr = 1'b1;
`else
    exp_clr = 1'b0;
`endif
    step(1'b1, 4'b1000, 64'd42);
    n_tests++;
    if (clr !== exp_clr || data !== 32'd42) begin
      n_fail++;
      $display("FAIL clr_lo: got clr=%b data=%h, want %b/0000002a", clr, data, exp_clr);
    end
    step(1'b1, 4'b0000, 64'd0);
    n_tests++;
    if (clr !== 1'b0 || data !== 32'd0 || last !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_hi: got clr=%b data=%h last=%b, want 0/00000000/1", clr, data, last);
    end
    step(1'b1, 4'b0000, 64'd0);
  endtask

  task automatic test_random();
    logic r;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 49) != 0);
      step(r, N'($urandom), {$urandom, $urandom});
      n_tests++;
      if ({ack, last, busy, gnt, gnt_id, clr} !== {e_ack, e_last, e_busy, e_gnt, e_id, e_clr} ||
          (e_ack && data !== e_data)) begin
        n_fail++;
        $display("FAIL random cyc%0d: got ack=%b last=%b busy=%b gnt=%b id=%0d clr=%b data=%h, want %b %b %b %b %0d %b %h",
                 i, ack, last, busy, gnt, gnt_id, clr, data,
                 e_ack, e_last, e_busy, e_gnt, e_id, e_clr, e_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_no_tear();
    test_round_robin();
    test_drop_and_reset();
    test_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
